// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the 8-bit processor control sequencer:
//               opcode values, sequencer state encoding and instruction-field
//               bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Opcodes (ir[15:12]); 7..15 are undefined
    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_JMP   = 4'd4;
    localparam logic [3:0] OP_JZ    = 4'd5;
    localparam logic [3:0] OP_HALT  = 4'd6;

    // Sequencer states, 4-bit encoding
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_LATCH  = 4'd2,
        S_DECODE = 4'd3,
        S_LD_MEM = 4'd4,
        S_LD_WB  = 4'd5,
        S_ST_RD  = 4'd6,
        S_ST_MEM = 4'd7,
        S_RD_A   = 4'd8,
        S_RD_B   = 4'd9,
        S_WB     = 4'd10,
        S_HALT   = 4'd11
    } state_e;

    // Instruction field slice positions
    localparam int c_opc_hi  = 15;
    localparam int c_opc_lo  = 12;
    localparam int c_rd_hi   = 11;
    localparam int c_rd_lo   = 8;
    localparam int c_rs_hi   = 7;
    localparam int c_rs_lo   = 4;
    localparam int c_rt_hi   = 3;
    localparam int c_rt_lo   = 0;
    localparam int c_addr_hi = 7;
    localparam int c_addr_lo = 0;

endpackage
`default_nettype wire

// File: rtl/pc_counter.sv
`default_nettype none
// ============================================================================
// Module      : pc_counter
// Description : Program counter register with asynchronous active-high reset.
//               load_i has priority over inc_i; increment wraps modulo 2^PC_W.
// Ports       : clk, rst         - clock, async active-high reset
//               inc_i            - advance pc by one
//               load_i           - overwrite pc with load_val_i
//               load_val_i       - jump target
//               pc_o             - current program counter
// Revision    : 1.0 - initial release
// ============================================================================
module pc_counter
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_i,
    input  logic            load_i,
    input  logic [PC_W-1:0] load_val_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_fsm
// Description : Multi-cycle fetch/decode/execute sequencer for the 8-bit
//               processor. Owns pc and ir and issues every one-cycle read and
//               write strobe to instruction memory, register file, data memory
//               and the ALU/write-back path.
// Ports       : clk, reset       - clock, async active-high reset
//               start            - begin execution (sampled in IDLE only)
//               imem_data        - instruction memory read data
//               zero             - ALU zero flag (sampled in DECODE only)
//               imem_addr/imem_rd           - instruction fetch
//               rf_addr/rf_re/rf_we/rf_wsel - register file control
//               alu_a_ld/alu_b_ld/alu_op    - ALU operand latch and op
//               dmem_addr/dmem_re/dmem_we   - data memory control
//               busy/halted/illegal         - status
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int IR_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IR_W-1:0] imem_data,
    input  logic            zero,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd,
    output logic [3:0]      rf_addr,
    output logic            rf_re,
    output logic            rf_we,
    output logic            rf_wsel,
    output logic            alu_a_ld,
    output logic            alu_b_ld,
    output logic            alu_op,
    output logic [7:0]      dmem_addr,
    output logic            dmem_re,
    output logic            dmem_we,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    state_e          state_q;
    state_e          state_d;
    logic [IR_W-1:0] ir_q;
    logic [IR_W-1:0] ir_d;
    logic            illegal_q;
    logic            illegal_d;

    logic            w_pc_inc;
    logic            w_pc_load;
    logic [PC_W-1:0] w_pc;
    logic [3:0]      w_opcode;
    logic [3:0]      w_rd;
    logic [3:0]      w_rs;
    logic [3:0]      w_rt;
    logic [7:0]      w_addr8;

    assign w_opcode = ir_q[c_opc_hi:c_opc_lo];
    assign w_rd     = ir_q[c_rd_hi:c_rd_lo];
    assign w_rs     = ir_q[c_rs_hi:c_rs_lo];
    assign w_rt     = ir_q[c_rt_hi:c_rt_lo];
    assign w_addr8  = ir_q[c_addr_hi:c_addr_lo];

    pc_counter #(
        .PC_W       (PC_W)
    ) u_pc_counter (
        .clk        (clk),
        .rst        (reset),
        .inc_i      (w_pc_inc),
        .load_i     (w_pc_load),
        .load_val_i (PC_W'(w_addr8)),
        .pc_o       (w_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes depend on state_q and ir_q only; zero affects just the pc load.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        w_pc_inc  = 1'b0;
        w_pc_load = 1'b0;
        imem_rd   = 1'b0;
        rf_addr   = 4'd0;
        rf_re     = 1'b0;
        rf_we     = 1'b0;
        rf_wsel   = 1'b0;
        alu_a_ld  = 1'b0;
        alu_b_ld  = 1'b0;
        alu_op    = 1'b0;
        dmem_re   = 1'b0;
        dmem_we   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_rd = 1'b1;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                ir_d     = imem_data;
                w_pc_inc = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                case (w_opcode)
                    OP_LOAD:  state_d = S_LD_MEM;
                    OP_STORE: state_d = S_ST_RD;
                    OP_ADD,
                    OP_SUB:   state_d = S_RD_A;
                    OP_JMP: begin
                        w_pc_load = 1'b1;
                        state_d   = S_FETCH;
                    end
                    OP_JZ: begin
                        w_pc_load = zero;
                        state_d   = S_FETCH;
                    end
                    OP_HALT:  state_d = S_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_LD_MEM: begin
                dmem_re = 1'b1;
                state_d = S_LD_WB;
            end
            S_LD_WB: begin
                rf_we   = 1'b1;
                rf_addr = w_rd;
                rf_wsel = 1'b1;
                state_d = S_FETCH;
            end
            S_ST_RD: begin
                rf_re   = 1'b1;
                rf_addr = w_rd;
                state_d = S_ST_MEM;
            end
            S_ST_MEM: begin
                dmem_we = 1'b1;
                state_d = S_FETCH;
            end
            S_RD_A: begin
                rf_re    = 1'b1;
                rf_addr  = w_rs;
                alu_a_ld = 1'b1;
                state_d  = S_RD_B;
            end
            S_RD_B: begin
                rf_re    = 1'b1;
                rf_addr  = w_rt;
                alu_b_ld = 1'b1;
                state_d  = S_WB;
            end
            S_WB: begin
                rf_we   = 1'b1;
                rf_addr = w_rd;
                alu_op  = w_opcode[0];
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_addr = w_pc;
    assign dmem_addr = w_addr8;
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_control_fsm
// Description : Self-checking bench for cpu_control_fsm. Contains instruction,
//               register-file and data memories plus operand glue, and an
//               instruction-level model that lists the expected outputs cycle
//               by cycle for each program.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_control_fsm;

    typedef struct packed {
        logic [7:0] imem_addr;
        logic       imem_rd;
        logic [3:0] rf_addr;
        logic       rf_re;
        logic       rf_we;
        logic       rf_wsel;
        logic       alu_a_ld;
        logic       alu_b_ld;
        logic       alu_op;
        logic [7:0] dmem_addr;
        logic       dmem_re;
        logic       dmem_we;
        logic       busy;
        logic       halted;
        logic       illegal;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        zero = 1'b0;
    logic [15:0] imem_data;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [3:0]  rf_addr;
    logic        rf_re;
    logic        rf_we;
    logic        rf_wsel;
    logic        alu_a_ld;
    logic        alu_b_ld;
    logic        alu_op;
    logic [7:0]  dmem_addr;
    logic        dmem_re;
    logic        dmem_we;
    logic        busy;
    logic        halted;
    logic        illegal;

    cpu_control_fsm #(.PC_W(8), .IR_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .imem_data (imem_data),
        .zero      (zero),
        .imem_addr (imem_addr),
        .imem_rd   (imem_rd),
        .rf_addr   (rf_addr),
        .rf_re     (rf_re),
        .rf_we     (rf_we),
        .rf_wsel   (rf_wsel),
        .alu_a_ld  (alu_a_ld),
        .alu_b_ld  (alu_b_ld),
        .alu_op    (alu_op),
        .dmem_addr (dmem_addr),
        .dmem_re   (dmem_re),
        .dmem_we   (dmem_we),
        .busy      (busy),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // ---------------- environment: memories and operand glue ----------------
    logic [15:0] imem [256];
    logic [7:0]  rf   [16];
    logic [7:0]  dmem [256];
    logic [7:0]  rf_rd_q = 8'h00;
    logic [7:0]  dm_rd_q = 8'h00;
    logic [7:0]  opa_q = 8'h00;
    logic        a_ld_dly = 1'b0;
    logic        pk_en = 1'b0;
    logic        pk_sel = 1'b0;
    logic [7:0]  pk_addr = 8'h00;
    logic [7:0]  pk_val = 8'h00;

    assign imem_data = imem[imem_addr];

    always @(posedge clk) begin
        logic [7:0] wv;
        logic [7:0] rd_old;
        wv     = rf_wsel ? dm_rd_q : (alu_op ? opa_q - rf_rd_q : opa_q + rf_rd_q);
        rd_old = rf_rd_q;
        if (rf_we)   rf[rf_addr] = wv;
        if (dmem_we) dmem[dmem_addr] = rd_old;
        if (a_ld_dly) opa_q = rd_old;
        a_ld_dly = alu_a_ld;
        if (rf_re)   rf_rd_q = rf[rf_addr];
        if (dmem_re) dm_rd_q = dmem[dmem_addr];
        if (pk_en) begin
            if (pk_sel) dmem[pk_addr] = pk_val;
            else        rf[pk_addr[3:0]] = pk_val;
        end
    end

    // ---------------- bookkeeping ----------------
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   halt_cyc = -1;
    int   model_halt_idx = -1;
    int   fetch_q[$];
    obs_t exp_q[$];
    bit   chk_en = 1'b0;
    bit   pulse_start = 1'b0;

    function automatic obs_t cur();
        obs_t o;
        o.imem_addr = imem_addr;
        o.imem_rd   = imem_rd;
        o.rf_addr   = rf_addr;
        o.rf_re     = rf_re;
        o.rf_we     = rf_we;
        o.rf_wsel   = rf_wsel;
        o.alu_a_ld  = alu_a_ld;
        o.alu_b_ld  = alu_b_ld;
        o.alu_op    = alu_op;
        o.dmem_addr = dmem_addr;
        o.dmem_re   = dmem_re;
        o.dmem_we   = dmem_we;
        o.busy      = busy;
        o.halted    = halted;
        o.illegal   = illegal;
        return o;
    endfunction

    function automatic obs_t mk(logic [7:0] pc, logic [15:0] ir, logic ill);
        obs_t o;
        o           = '0;
        o.imem_addr = pc;
        o.dmem_addr = ir[7:0];
        o.busy      = 1'b1;
        o.illegal   = ill;
        return o;
    endfunction

    // Instruction-level model: walks the program from pc 0 and lists the
    // expected output vector for each cycle, starting with the first fetch.
    task automatic build_trace(input logic zv, input int max_len, input int tail);
        logic [7:0]  pc;
        logic [15:0] ir;
        logic        ill;
        logic [3:0]  op;
        obs_t        o;
        bit          done;
        exp_q.delete();
        pc = 8'h00; ir = 16'h0000; ill = 1'b0; done = 1'b0; model_halt_idx = -1;
        while (!done && exp_q.size() < max_len) begin
            o = mk(pc, ir, ill); o.imem_rd = 1'b1; exp_q.push_back(o);
            exp_q.push_back(mk(pc, ir, ill));
            ir = imem[pc];
            pc = pc + 8'd1;
            exp_q.push_back(mk(pc, ir, ill));
            op = ir[15:12];
            case (op)
                4'd0: begin
                    o = mk(pc, ir, ill); o.dmem_re = 1'b1; exp_q.push_back(o);
                    o = mk(pc, ir, ill); o.rf_we = 1'b1; o.rf_addr = ir[11:8];
                    o.rf_wsel = 1'b1; exp_q.push_back(o);
                end
                4'd1: begin
                    o = mk(pc, ir, ill); o.rf_re = 1'b1; o.rf_addr = ir[11:8]; exp_q.push_back(o);
                    o = mk(pc, ir, ill); o.dmem_we = 1'b1; exp_q.push_back(o);
                end
                4'd2, 4'd3: begin
                    o = mk(pc, ir, ill); o.rf_re = 1'b1; o.rf_addr = ir[7:4];
                    o.alu_a_ld = 1'b1; exp_q.push_back(o);
                    o = mk(pc, ir, ill); o.rf_re = 1'b1; o.rf_addr = ir[3:0];
                    o.alu_b_ld = 1'b1; exp_q.push_back(o);
                    o = mk(pc, ir, ill); o.rf_we = 1'b1; o.rf_addr = ir[11:8];
                    o.alu_op = op[0]; exp_q.push_back(o);
                end
                4'd4: pc = ir[7:0];
                4'd5: if (zv) pc = ir[7:0];
                default: begin
                    if (op > 4'd6) ill = 1'b1;
                    done = 1'b1;
                end
            endcase
        end
        if (done) begin
            model_halt_idx = exp_q.size();
            repeat (tail) begin
                o = '0; o.imem_addr = pc; o.dmem_addr = ir[7:0];
                o.halted = 1'b1; o.illegal = ill; exp_q.push_back(o);
            end
        end
        while (exp_q.size() > max_len) void'(exp_q.pop_back());
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock step, sampled at the falling edge; compares against the
    // model trace whenever a program run is being checked.
    task automatic tick();
        obs_t e;
        obs_t a;
        @(negedge clk);
        cyc++;
        if (imem_rd === 1'b1) fetch_q.push_back(cyc);
        if (halted === 1'b1 && halt_cyc < 0) halt_cyc = cyc;
        if (chk_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = cur();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL cycle_outputs cyc=%0d actual=%h required=%h", cyc, a, e);
            end
        end
    endtask

    task automatic poke(input bit sel, input logic [7:0] addr, input logic [7:0] val);
        pk_sel = sel; pk_addr = addr; pk_val = val; pk_en = 1'b1;
        @(posedge clk);
        #1 pk_en = 1'b0;
    endtask

    task automatic rst_on();
        @(negedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b0;
        start  = 1'b0;
        #1 check("reset_outputs", 32'(cur()), 32'h0);
    endtask

    task automatic rst_off();
        @(negedge clk);
        #1 reset = 1'b0;
        fetch_q.delete();
        halt_cyc = -1;
    endtask

    task automatic run_trace();
        tick();
        #1 start = 1'b1;
        chk_en = 1'b1;
        tick();
        #1 start = 1'b0;
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
            tick();
            #1 if (pulse_start) start = (i % 2 == 0);
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL trace_timeout actual=%0d required=0", exp_q.size());
        end
        chk_en = 1'b0;
        start  = 1'b0;
        pulse_start = 1'b0;
    endtask

    function automatic int fetch_at(int k);
        if (k < fetch_q.size()) return fetch_q[k];
        return -1000;
    endfunction

    initial begin
        bit found;
        for (int i = 0; i < 256; i++) imem[i] = 16'h6000;

        // ---- HALT at address 0 ----
        rst_on();
        rst_off();
        zero = 1'b0;
        build_trace(1'b0, 64, 3);
        check("model_halt_latency", 32'(model_halt_idx), 32'd3);
        run_trace();
        check("halt_imem_rd_pulses", 32'(fetch_q.size()), 32'd1);
        check("halt_latency", 32'(halt_cyc - fetch_at(0)), 32'd3);
        check("halt_pc", 32'(imem_addr), 32'h01);
        check("halt_illegal", 32'(illegal), 32'h0);
        check("halt_halted", 32'(halted), 32'h1);

        // ---- LOAD r3,[5]; STORE r3,[7]; HALT ----
        imem[0] = 16'h0305; imem[1] = 16'h1307; imem[2] = 16'h6000;
        rst_on();
        poke(1'b1, 8'h05, 8'hA5);
        poke(1'b1, 8'h07, 8'h00);
        poke(1'b0, 8'h03, 8'h00);
        rst_off();
        build_trace(1'b0, 64, 3);
        check("model_ldst_len", 32'(model_halt_idx), 32'd13);
        run_trace();
        check("ldst_r3", 32'(rf[3]), 32'hA5);
        check("ldst_dmem7", 32'(dmem[7]), 32'hA5);

        // ---- ADD r4 = r1 + r2 (wraps) ----
        imem[0] = 16'h2412; imem[1] = 16'h6000; imem[2] = 16'h6000;
        rst_on();
        poke(1'b0, 8'h01, 8'hF0);
        poke(1'b0, 8'h02, 8'h20);
        poke(1'b0, 8'h04, 8'h00);
        rst_off();
        build_trace(1'b0, 64, 3);
        check("model_add_len", 32'(model_halt_idx), 32'd9);
        run_trace();
        check("add_r4", 32'(rf[4]), 32'h10);
        check("add_cycles", 32'(fetch_at(1) - fetch_at(0)), 32'd6);

        // ---- SUB r4 = r1 - r2 ----
        imem[0] = 16'h3412;
        rst_on();
        poke(1'b0, 8'h04, 8'h00);
        rst_off();
        build_trace(1'b0, 64, 3);
        run_trace();
        check("sub_r4", 32'(rf[4]), 32'hD0);

        // ---- JZ not taken / taken ----
        imem[0] = 16'h5040;
        rst_on();
        rst_off();
        zero = 1'b0;
        build_trace(1'b0, 64, 3);
        run_trace();
        check("jz_nt_pc", 32'(imem_addr), 32'h02);
        check("jz_nt_cycles", 32'(fetch_at(1) - fetch_at(0)), 32'd3);
        rst_on();
        rst_off();
        zero = 1'b1;
        build_trace(1'b1, 64, 3);
        run_trace();
        check("jz_t_pc", 32'(imem_addr), 32'h41);
        zero = 1'b0;

        // ---- JMP to 0xFF, HALT there: pc wraps to 0x00 ----
        imem[0] = 16'h40FF;
        rst_on();
        rst_off();
        build_trace(1'b0, 64, 3);
        run_trace();
        check("wrap_pc", 32'(imem_addr), 32'h00);
        check("wrap_halted", 32'(halted), 32'h1);

        // ---- JMP to self loops forever ----
        imem[0] = 16'h4000;
        rst_on();
        rst_off();
        build_trace(1'b0, 30, 0);
        run_trace();
        check("loop_fetches", 32'(fetch_q.size()), 32'd10);
        check("loop_busy", 32'(busy), 32'h1);
        check("loop_illegal", 32'(illegal), 32'h0);

        // ---- Illegal opcode, start pulses afterwards ignored ----
        imem[0] = 16'hB000;
        rst_on();
        rst_off();
        build_trace(1'b0, 64, 8);
        pulse_start = 1'b1;
        run_trace();
        check("ill_flag", 32'(illegal), 32'h1);
        check("ill_halted", 32'(halted), 32'h1);
        check("ill_pc", 32'(imem_addr), 32'h01);
        rst_on();
        check("ill_cleared", 32'(illegal), 32'h0);
        rst_off();

        // ---- Reset during LD_WB drops the write ----
        imem[0] = 16'h0305;
        rst_on();
        poke(1'b1, 8'h05, 8'hA5);
        poke(1'b0, 8'h03, 8'h11);
        rst_off();
        tick();
        #1 start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            #1 start = 1'b0;
            if (rf_we === 1'b1) found = 1'b1;
        end
        check("ldwb_reached", 32'(found), 32'h1);
        reset = 1'b1;
        #1;
        check("abort_rf_we", 32'(rf_we), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_pc", 32'(imem_addr), 32'h00);
        check("abort_halted", 32'(halted), 32'h0);
        @(posedge clk);
        #1;
        check("abort_r3", 32'(rf[3]), 32'h11);
        rst_off();
        tick();
        check("abort_idle", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle control sequencer for the 8-bit processor. It owns the program counter and instruction register and steps each instruction through fetch, decode and execute. In each state it drives one-cycle enable strobes to the instruction memory, register file, data memory and the ALU/write-back mux. It sits between those storage blocks and the datapath glue, and is the only block that issues their read and write enables.

## Interface
Parameters:
- `PC_W`, default 8: program counter and instruction-memory address width.
- `IR_W`, default 16: instruction width.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: level input, sampled in IDLE; begins execution at the current `pc`.
- `imem_data` in 16: instruction-memory output.
- `zero` in 1: ALU zero flag from the datapath.
- `imem_addr` out 8: equals `pc`.
- `imem_rd` out 1: instruction-memory read strobe.
- `rf_addr` out 4: register-file address.
- `rf_re` out 1: register-file read strobe.
- `rf_we` out 1: register-file write strobe.
- `rf_wsel` out 1: write-back mux select; 0 selects the ALU result, 1 selects data-memory output.
- `alu_a_ld` out 1: datapath latches the register-file output into ALU operand A.
- `alu_b_ld` out 1: datapath latches the register-file output into ALU operand B.
- `alu_op` out 1: 0 selects add, 1 selects subtract.
- `dmem_addr` out 8: data-memory address, equals `ir[7:0]`.
- `dmem_re` out 1: data-memory read strobe.
- `dmem_we` out 1: data-memory write strobe.
- `busy` out 1: high in every state except IDLE and HALT.
- `halted` out 1: high in HALT.
- `illegal` out 1: sticky flag; set when an undefined opcode is decoded.

## Operation
Instruction format:
- `ir[15:12]`: opcode.
- `ir[11:8]`: destination/source register rd.
- `ir[7:4]`: rs.
- `ir[3:0]`: rt.
- `ir[7:0]`: addr8.

Opcodes:
- 0 LOAD: rd ← dmem[addr8].
- 1 STORE: dmem[addr8] ← rd.
- 2 ADD: rd ← rs+rt, modulo 256.
- 3 SUB: rd ← rs−rt, modulo 256.
- 4 JMP: pc ← addr8.
- 5 JZ: pc ← addr8 if `zero`=1.
- 6 HALT.
- 7–15 illegal: set `illegal`, go to HALT.

States (Moore machine; strobes are decoded from state and `ir` only):
- IDLE: all strobes 0. Goes to FETCH when `start`=1.
- FETCH: `imem_rd`=1. Goes to LATCH.
- LATCH: `ir` ← `imem_data`; `pc` ← `pc`+1 (8-bit, 0xFF wraps to 0x00). Goes to DECODE.
- DECODE: branches on opcode.
  - JMP: `pc` ← addr8.
  - JZ with `zero`=1: `pc` ← addr8.
  - JMP and JZ (either outcome) go to FETCH.
  - LOAD goes to LD_MEM; STORE goes to ST_RD; ADD/SUB go to RD_A; HALT goes to HALT.
- LD_MEM: `dmem_re`=1. Goes to LD_WB.
- LD_WB: `rf_we`=1, `rf_addr`=rd, `rf_wsel`=1. Goes to FETCH.
- ST_RD: `rf_re`=1, `rf_addr`=rd. Goes to ST_MEM.
- ST_MEM: `dmem_we`=1. Goes to FETCH.
- RD_A: `rf_re`=1, `rf_addr`=rs, `alu_a_ld`=1. Goes to RD_B.
- RD_B: `rf_re`=1, `rf_addr`=rt, `alu_b_ld`=1. Goes to WB.
- WB: `rf_we`=1, `rf_addr`=rd, `rf_wsel`=0, `alu_op`=opcode[0]. Goes to FETCH.
- HALT: all strobes 0. Leaves only via `reset`.

Signal rules:
- `rf_addr`, `alu_op` and `rf_wsel` are 0 in states where they are not specified.
- Read and write strobes are never high together on the same target.

## Timing
Reset values (applied immediately on `reset`, independent of `clk`):
- State is IDLE; `pc`=0x00, `ir`=0x0000, `illegal`=0.
- Every output is 0, except `imem_addr`, which equals `pc`.

Strobe and data timing:
- Each strobe is high for exactly one cycle per assertion. This gives the level/event-sensitive memories a clean 0→1 edge.
- `imem_data` is valid during LATCH and is captured at the end of that cycle.
- Register-file read data is valid during the cycle after `rf_re` rises. The datapath latches operands on the clock edge that ends RD_B and WB, i.e. the edge following the cycle where `alu_*_ld` is asserted.

Cycles per instruction, counted FETCH to the next FETCH:
- JMP/JZ: 3.
- LOAD, STORE: 5.
- ADD/SUB: 6.
- HALT reaches the HALT state 3 cycles after FETCH.

Boundary conditions:
- `start` is ignored outside IDLE.
- `zero` is sampled only in DECODE.
- A JMP to the instruction's own address loops forever without error.
- The `pc` increment in LATCH happens before the jump overwrite in DECODE, so the jump target wins.
- `reset` asserted mid-instruction aborts it. A write strobe that is high is dropped in the same cycle, and no partial update is retried.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams (`OP_LOAD`…`OP_HALT`);
  - the state enum (4-bit encoding);
  - instruction field slice positions.
- One sub-module, `pc_counter`, owns the 8-bit `pc` register with async reset. It has increment and load inputs, and load has priority over increment.

## Test plan
- Reset, then `start`. With imem[0]=0x6000 (HALT): `imem_rd` pulses once at cycle 1; `halted`=1 at cycle 3; `pc`=0x01; `illegal`=0.
- Program 0x0305 (LOAD r3,[0x05]), 0x1307 (STORE r3,[0x07]), 0x6000 (HALT), with dmem[5]=0xA5: `dmem_re` pulses with addr 0x05, then `rf_we` with `rf_addr`=3 and `rf_wsel`=1, then `dmem_we` with addr 0x07; dmem[7]=0xA5 at halt.
- ADD 0x2412 with r1=0xF0, r2=0x20: `alu_a_ld` and `alu_b_ld` assert in consecutive cycles on addresses 1 then 2; r4=0x10 (wrap); instruction takes 6 cycles.
- JZ 0x5040 with `zero`=0 → next fetch at pc=0x01. With `zero`=1 → next fetch at 0x40. JMP at 0xFF to 0x00 also verifies wrap.
- Opcode 0xB000 → `illegal`=1 and `halted`=1; `start` pulses afterwards have no effect.
- Assert `reset` during LD_WB → `rf_we` drops within the same cycle; register unchanged; `pc`=0x00; state IDLE.
